reorder_tag_manager: RTL and testbench

Allocates reorder tags to packets entering the filter farm, records each packet's accept/reject verdict, and presents that verdict to `circular_buffer` as `packet_status` for the tag it is currently draining. It sits directly upstream of `circular_buffer` on the ingress AXI-Stream path and is the sole driver of its `reorder_tag_in` and `packet_status` inputs. Ingress is stalled whenever all `CIRCULAR_BUFFER_SIZE` tags are in flight.

---
 rtl/reorder_pkg.sv | 23 ++
 rtl/reorder_tag_manager_if.sv | 49 ++++
 rtl/reorder_tag_manager_status_table.sv | 69 ++++++
 rtl/reorder_tag_manager.sv | 103 ++++++++++
 tb/tb_reorder_tag_manager.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_pkg.sv
`default_nettype none
// ============================================================================
// Package : reorder_pkg
// Brief   : Tag-status encodings and default sizing shared by the reorder path.
// Rev     : 1.0 - initial release
// ============================================================================
package reorder_pkg;

    localparam int DEFAULT_TAG_WIDTH            = 6;
    localparam int DEFAULT_CIRCULAR_BUFFER_SIZE = 50;
    localparam int DEFAULT_DATA_WIDTH           = 64;

    localparam logic [1:0] PENDING  = 2'b00;
    localparam logic [1:0] REJECTED = 2'b01;
    localparam logic [1:0] ACCEPTED = 2'b11;

    typedef struct packed {
        logic       live;
        logic [1:0] status;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_tag_manager_if.sv
`default_nettype none
// ============================================================================
// Interface : reorder_tag_manager_if
// Brief     : Ingress/egress stream, verdict, drain and release signals.
// Rev       : 1.0 - initial release
// ============================================================================
interface reorder_tag_manager_if
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] up_TDATA;
    logic                  up_TVALID;
    logic                  up_TLAST;
    logic                  up_TREADY;
    logic [DATA_WIDTH-1:0] buffer_TDATA;
    logic                  buffer_TVALID;
    logic                  buffer_TLAST;
    logic                  buffer_TREADY;
    logic [TAG_WIDTH-1:0]  reorder_tag_in;
    logic                  verdict_valid;
    logic [TAG_WIDTH-1:0]  verdict_tag;
    logic                  verdict_accept;
    logic [TAG_WIDTH-1:0]  reorder_tag_out;
    logic [1:0]            packet_status;
    logic                  release_valid;
    logic [TAG_WIDTH-1:0]  release_tag;
    logic                  err;

    modport master (
        input  up_TDATA, up_TVALID, up_TLAST, buffer_TREADY,
               verdict_valid, verdict_tag, verdict_accept,
               reorder_tag_out, release_valid, release_tag,
        output up_TREADY, buffer_TDATA, buffer_TVALID, buffer_TLAST,
               reorder_tag_in, packet_status, err
    );

    modport slave (
        output up_TDATA, up_TVALID, up_TLAST, buffer_TREADY,
               verdict_valid, verdict_tag, verdict_accept,
               reorder_tag_out, release_valid, release_tag,
        input  up_TREADY, buffer_TDATA, buffer_TVALID, buffer_TLAST,
               reorder_tag_in, packet_status, err
    );

endinterface
`default_nettype wire

// File: rtl/reorder_tag_manager_status_table.sv
`default_nettype none
// ============================================================================
// Module : status_table
// Brief  : Per-tag {live, status} storage; release beats verdict on one entry.
// Rev    : 1.0 - initial release
// ============================================================================
module status_table
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH,
    parameter int SIZE      = DEFAULT_CIRCULAR_BUFFER_SIZE
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_alloc_en,
    input  wire logic [TAG_WIDTH-1:0] i_alloc_tag,
    input  wire logic                 i_verdict_en,
    input  wire logic [TAG_WIDTH-1:0] i_verdict_tag,
    input  wire logic                 i_verdict_accept,
    input  wire logic                 i_release_en,
    input  wire logic [TAG_WIDTH-1:0] i_release_tag,
    input  wire logic [TAG_WIDTH-1:0] i_rd_tag,
    output logic                      o_verdict_ok,
    output logic                      o_release_live,
    output logic [1:0]                o_rd_status
);

    localparam entry_t c_EMPTY = '{live: 1'b0, status: PENDING};

    entry_t     r_entry [SIZE];
    entry_t     w_v_entry;
    logic       w_r_live;
    logic [1:0] w_rd_status;

    // Decoded lookups: tags beyond SIZE match nothing and read as empty.
    always_comb begin
        w_v_entry   = c_EMPTY;
        w_r_live    = 1'b0;
        w_rd_status = PENDING;
        for (int i = 0; i < SIZE; i++) begin
            if (i_verdict_tag == TAG_WIDTH'(i)) w_v_entry   = r_entry[i];
            if (i_release_tag == TAG_WIDTH'(i)) w_r_live    = r_entry[i].live;
            if (i_rd_tag == TAG_WIDTH'(i))      w_rd_status = r_entry[i].status;
        end
    end

    assign o_verdict_ok   = i_verdict_en && w_v_entry.live && (w_v_entry.status == PENDING);
    assign o_release_live = w_r_live;
    assign o_rd_status    = w_rd_status;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) r_entry[i] <= c_EMPTY;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (i_release_en && (i_release_tag == TAG_WIDTH'(i))) begin
                    r_entry[i] <= c_EMPTY;
                end else begin
                    if (i_alloc_en && (i_alloc_tag == TAG_WIDTH'(i)))
                        r_entry[i].live <= 1'b1;
                    if (o_verdict_ok && (i_verdict_tag == TAG_WIDTH'(i)))
                        r_entry[i].status <= i_verdict_accept ? ACCEPTED : REJECTED;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reorder_tag_manager.sv
`default_nettype none
// ============================================================================
// Module : reorder_tag_manager
// Brief  : Allocates reorder tags on ingress, tracks verdicts, feeds drain status.
// Rev    : 1.0 - initial release
// ============================================================================
module reorder_tag_manager
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH            = DEFAULT_TAG_WIDTH,
    parameter int CIRCULAR_BUFFER_SIZE = DEFAULT_CIRCULAR_BUFFER_SIZE,
    parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    reorder_tag_manager_if.master bus
);

    localparam logic [TAG_WIDTH-1:0] c_LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);
    localparam logic [TAG_WIDTH:0]   c_SIZE     = (TAG_WIDTH + 1)'(CIRCULAR_BUFFER_SIZE);

    logic [TAG_WIDTH-1:0]  r_next_tag;
    logic [TAG_WIDTH-1:0]  r_head_tag;
    logic [TAG_WIDTH-1:0]  r_cur_tag;
    logic [TAG_WIDTH:0]    r_in_flight;
    logic                  r_mid_packet;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_open;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_alloc;
    logic                  w_rel_live;
    logic                  w_rel_ok;
    logic                  w_verdict_ok;
    logic                  w_verdict_err;

    // Gate uses the registered count only: a release never frees a slot in its own cycle.
    assign w_open  = r_mid_packet || (r_in_flight < c_SIZE);
    assign w_ready = bus.buffer_TREADY && w_open;
    assign w_xfer  = bus.up_TVALID && w_ready;
    assign w_alloc = w_xfer && !r_mid_packet;

    assign w_data             = bus.up_TDATA;
    assign bus.buffer_TDATA   = w_data;
    assign bus.buffer_TLAST   = bus.up_TLAST;
    assign bus.buffer_TVALID  = bus.up_TVALID && w_open;
    assign bus.up_TREADY      = w_ready;
    assign bus.reorder_tag_in = r_mid_packet ? r_cur_tag : r_next_tag;
    assign bus.err            = r_err;

    assign w_rel_ok      = bus.release_valid && (bus.release_tag == r_head_tag) && w_rel_live;
    assign w_verdict_err = bus.verdict_valid &&
                           (!w_verdict_ok || (w_rel_ok && (bus.release_tag == bus.verdict_tag)));

    status_table #(
        .TAG_WIDTH (TAG_WIDTH),
        .SIZE      (CIRCULAR_BUFFER_SIZE)
    ) u_status_table (
        .clk              (clk),
        .rst              (rst),
        .i_alloc_en       (w_alloc),
        .i_alloc_tag      (r_next_tag),
        .i_verdict_en     (bus.verdict_valid),
        .i_verdict_tag    (bus.verdict_tag),
        .i_verdict_accept (bus.verdict_accept),
        .i_release_en     (w_rel_ok),
        .i_release_tag    (bus.release_tag),
        .i_rd_tag         (bus.reorder_tag_out),
        .o_verdict_ok     (w_verdict_ok),
        .o_release_live   (w_rel_live),
        .o_rd_status      (bus.packet_status)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_tag   <= '0;
            r_head_tag   <= '0;
            r_cur_tag    <= '0;
            r_in_flight  <= '0;
            r_mid_packet <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_cur_tag  <= r_next_tag;
                r_next_tag <= (r_next_tag == c_LAST_TAG) ? '0 : r_next_tag + 1'b1;
            end
            if (w_xfer)
                r_mid_packet <= !bus.up_TLAST;
            if (w_rel_ok)
                r_head_tag <= (r_head_tag == c_LAST_TAG) ? '0 : r_head_tag + 1'b1;
            case ({w_alloc, w_rel_ok})
                2'b10:   r_in_flight <= r_in_flight + 1'b1;
                2'b01:   r_in_flight <= r_in_flight - 1'b1;
                default: r_in_flight <= r_in_flight;
            endcase
            if (w_verdict_err || (bus.release_valid && !w_rel_ok))
                r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_tag_manager.sv
`default_nettype none
// ============================================================================
// Module : tb_reorder_tag_manager
// Brief  : Scoreboarded bench for reorder_tag_manager with a 3-entry table.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_reorder_tag_manager;
    import reorder_pkg::*;

    localparam int TW   = 6;
    localparam int SIZE = 3;
    localparam int DW   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_tag_manager_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus_if ();

    reorder_tag_manager #(
        .TAG_WIDTH            (TW),
        .CIRCULAR_BUFFER_SIZE (SIZE),
        .DATA_WIDTH           (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [TW-1:0] tag_q [$];
    int            exp_next;
    logic          mon_mid = 1'b0;
    logic [TW-1:0] mon_tag = '0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int wrap_inc(input int t);
        return (t == SIZE - 1) ? 0 : t + 1;
    endfunction

    // Every transferred beat: first beat pops the scoreboard; all beats carry that tag.
    always @(negedge clk) begin
        if (rst) begin
            mon_mid = 1'b0;
        end else if (bus_if.buffer_TVALID && bus_if.buffer_TREADY) begin
            if (!mon_mid) begin
                check_eq("tag_q_nonempty", 64'(tag_q.size() != 0), 64'd1);
                if (tag_q.size() != 0) mon_tag = tag_q.pop_front();
            end
            check_eq("reorder_tag_in", 64'(bus_if.reorder_tag_in), 64'(mon_tag));
            check_eq("tdata_pass", 64'(bus_if.buffer_TDATA), 64'(bus_if.up_TDATA));
            check_eq("tlast_pass", 64'(bus_if.buffer_TLAST), 64'(bus_if.up_TLAST));
            mon_mid = !bus_if.up_TLAST;
        end
    end

    task automatic idle_inputs();
        bus_if.up_TVALID      = 1'b0;
        bus_if.up_TLAST       = 1'b0;
        bus_if.up_TDATA       = '0;
        bus_if.verdict_valid  = 1'b0;
        bus_if.verdict_tag    = '0;
        bus_if.verdict_accept = 1'b0;
        bus_if.release_valid  = 1'b0;
        bus_if.release_tag    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        bus_if.buffer_TREADY   = 1'b1;
        bus_if.reorder_tag_out = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tag_q.delete();
        exp_next = 0;
    endtask

    task automatic wait_ready(input string name);
        int w = 0;
        @(negedge clk);
        while (!bus_if.up_TREADY && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (w >= 30) check_eq(name, 64'(bus_if.up_TREADY), 64'd1);
    endtask

    task automatic send_packet(input int beats);
        tag_q.push_back(TW'(exp_next));
        exp_next = wrap_inc(exp_next);
        for (int b = 0; b < beats; b++) begin
            bus_if.up_TDATA  = {$urandom, $urandom};
            bus_if.up_TVALID = 1'b1;
            bus_if.up_TLAST  = (b == beats - 1);
            wait_ready("send_ready_timeout");
            @(posedge clk);
            #1;
        end
        bus_if.up_TVALID = 1'b0;
        bus_if.up_TLAST  = 1'b0;
    endtask

    task automatic give_verdict(input int t, input logic acc);
        bus_if.verdict_valid  = 1'b1;
        bus_if.verdict_tag    = TW'(t);
        bus_if.verdict_accept = acc;
        @(posedge clk);
        #1;
        bus_if.verdict_valid = 1'b0;
    endtask

    task automatic give_release(input int t);
        bus_if.release_valid = 1'b1;
        bus_if.release_tag   = TW'(t);
        @(posedge clk);
        #1;
        bus_if.release_valid = 1'b0;
    endtask

    task automatic expect_status(input string name, input int t, input logic [1:0] exp);
        bus_if.reorder_tag_out = TW'(t);
        #1;
        check_eq(name, 64'(bus_if.packet_status), 64'(exp));
    endtask

    task automatic run_soak();
        logic       m_live [SIZE];
        logic [1:0] m_status [SIZE];
        int m_head = 0, m_next = 0, m_inflight = 0, rem = 0, vt = 0, rt = 0;
        logic m_mid = 1'b0, holding = 1'b0, rel, ver, exp_open, xfer, last;
        for (int i = 0; i < SIZE; i++) begin
            m_live[i]   = 1'b0;
            m_status[i] = PENDING;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!holding) begin
                if ($urandom_range(0, 9) < 6) begin
                    if (rem == 0) begin
                        rem = $urandom_range(1, 4);
                        tag_q.push_back(TW'(exp_next));
                        exp_next = wrap_inc(exp_next);
                    end
                    bus_if.up_TVALID = 1'b1;
                    bus_if.up_TLAST  = (rem == 1);
                    bus_if.up_TDATA  = {$urandom, $urandom};
                    holding = 1'b1;
                end else begin
                    bus_if.up_TVALID = 1'b0;
                end
            end
            bus_if.buffer_TREADY = ($urandom_range(0, 9) < 6);
            rel = m_live[m_head] && ($urandom_range(0, 9) < 4);
            bus_if.release_valid = rel;
            bus_if.release_tag   = TW'(m_head);
            vt  = $urandom_range(0, SIZE - 1);
            ver = m_live[vt] && (m_status[vt] == PENDING) && !(rel && vt == m_head) &&
                  ($urandom_range(0, 9) < 5);
            bus_if.verdict_valid  = ver;
            bus_if.verdict_tag    = TW'(vt);
            bus_if.verdict_accept = $urandom_range(0, 1);
            rt = $urandom_range(0, SIZE - 1);
            bus_if.reorder_tag_out = TW'(rt);
            #1;
            exp_open = m_mid || (m_inflight < SIZE);
            check_eq("soak_tready", 64'(bus_if.up_TREADY), 64'(bus_if.buffer_TREADY && exp_open));
            check_eq("soak_status", 64'(bus_if.packet_status), 64'(m_status[rt]));
            xfer = bus_if.up_TVALID && bus_if.buffer_TREADY && exp_open;
            last = bus_if.up_TLAST;
            @(posedge clk);
            if (xfer) begin
                if (!m_mid) begin
                    m_live[m_next] = 1'b1;
                    m_next = wrap_inc(m_next);
                    m_inflight++;
                end
                m_mid   = !last;
                holding = 1'b0;
                rem--;
            end
            if (ver) m_status[vt] = bus_if.verdict_accept ? ACCEPTED : REJECTED;
            if (rel) begin
                m_live[m_head]   = 1'b0;
                m_status[m_head] = PENDING;
                m_head = wrap_inc(m_head);
                m_inflight--;
            end
            #1;
        end
        idle_inputs();
        #1;
        check_eq("soak_err", 64'(bus_if.err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        #1;
        check_eq("rst_tag_in", 64'(bus_if.reorder_tag_in), 64'd0);
        check_eq("rst_status", 64'(bus_if.packet_status), 64'(PENDING));
        check_eq("rst_tready", 64'(bus_if.up_TREADY), 64'd1);
        check_eq("rst_err", 64'(bus_if.err), 64'd0);
        bus_if.buffer_TREADY = 1'b0;
        #1;
        check_eq("rst_tready_follow", 64'(bus_if.up_TREADY), 64'd0);
        bus_if.buffer_TREADY = 1'b1;
        @(posedge clk);
        #1;

        // Basic flow and verdict visibility
        send_packet(3);
        send_packet(1);
        expect_status("tag0_pending", 0, PENDING);
        give_verdict(0, 1'b1);
        expect_status("tag0_accept", 0, ACCEPTED);
        give_verdict(1, 1'b0);
        give_release(0);
        expect_status("tag0_released", 0, PENDING);
        expect_status("tag1_reject", 1, REJECTED);
        check_eq("flow_err", 64'(bus_if.err), 64'd0);

        // Fill to SIZE, then stall until the head releases (no same-cycle bypass)
        send_packet(2);
        send_packet(1);
        tag_q.push_back(TW'(exp_next));
        exp_next = wrap_inc(exp_next);
        bus_if.up_TDATA  = {$urandom, $urandom};
        bus_if.up_TVALID = 1'b1;
        bus_if.up_TLAST  = 1'b1;
        #1;
        check_eq("full_tready", 64'(bus_if.up_TREADY), 64'd0);
        check_eq("full_tvalid", 64'(bus_if.buffer_TVALID), 64'd0);
        check_eq("full_tag", 64'(bus_if.reorder_tag_in), 64'd1);
        @(posedge clk);
        #1;
        bus_if.release_valid = 1'b1;
        bus_if.release_tag   = TW'(1);
        #1;
        check_eq("full_no_bypass", 64'(bus_if.up_TREADY), 64'd0);
        @(posedge clk);
        #1;
        bus_if.release_valid = 1'b0;
        #1;
        check_eq("full_reopen", 64'(bus_if.up_TREADY), 64'd1);
        @(posedge clk);
        #1;
        bus_if.up_TVALID = 1'b0;

        // Allocate last free tag and release head together: count unchanged
        give_release(2);
        tag_q.push_back(TW'(exp_next));
        exp_next = wrap_inc(exp_next);
        bus_if.up_TVALID     = 1'b1;
        bus_if.up_TLAST      = 1'b1;
        bus_if.release_valid = 1'b1;
        bus_if.release_tag   = TW'(0);
        #1;
        check_eq("simul_tready", 64'(bus_if.up_TREADY), 64'd1);
        @(posedge clk);
        #1;
        bus_if.up_TVALID     = 1'b0;
        bus_if.release_valid = 1'b0;
        send_packet(1);
        bus_if.up_TVALID = 1'b1;
        #1;
        check_eq("full_after_simul", 64'(bus_if.up_TREADY), 64'd0);
        bus_if.up_TVALID = 1'b0;
        check_eq("simul_err", 64'(bus_if.err), 64'd0);

        // Verdict and release on the same tag: release wins, err flagged
        bus_if.verdict_valid  = 1'b1;
        bus_if.verdict_tag    = TW'(1);
        bus_if.verdict_accept = 1'b1;
        bus_if.release_valid  = 1'b1;
        bus_if.release_tag    = TW'(1);
        @(posedge clk);
        #1;
        idle_inputs();
        expect_status("vr_same_status", 1, PENDING);
        check_eq("vr_same_err", 64'(bus_if.err), 64'd1);

        // Out-of-order release
        do_reset();
        send_packet(1);
        send_packet(1);
        give_verdict(1, 1'b1);
        check_eq("ooo_pre_err", 64'(bus_if.err), 64'd0);
        give_release(1);
        check_eq("ooo_err", 64'(bus_if.err), 64'd1);
        expect_status("ooo_tag1_kept", 1, ACCEPTED);

        // Verdict on a non-live tag
        do_reset();
        send_packet(1);
        give_verdict(2, 1'b1);
        check_eq("nonlive_err", 64'(bus_if.err), 64'd1);
        expect_status("nonlive_status", 2, PENDING);

        // Repeated verdict
        do_reset();
        send_packet(1);
        give_verdict(0, 1'b0);
        check_eq("rep_first_err", 64'(bus_if.err), 64'd0);
        expect_status("rep_first_status", 0, REJECTED);
        give_verdict(0, 1'b1);
        check_eq("rep_err", 64'(bus_if.err), 64'd1);
        expect_status("rep_status_kept", 0, REJECTED);

        // Out-of-range tag: reads PENDING, verdict flags err one cycle later
        do_reset();
        expect_status("oor_status", 5, PENDING);
        bus_if.verdict_valid  = 1'b1;
        bus_if.verdict_tag    = TW'(5);
        bus_if.verdict_accept = 1'b1;
        #1;
        check_eq("oor_err_not_yet", 64'(bus_if.err), 64'd0);
        @(posedge clk);
        #1;
        bus_if.verdict_valid = 1'b0;
        check_eq("oor_err", 64'(bus_if.err), 64'd1);

        // Reset in the middle of a packet: remainder is a fresh packet
        do_reset();
        tag_q.push_back(TW'(0));
        bus_if.up_TDATA  = {$urandom, $urandom};
        bus_if.up_TVALID = 1'b1;
        bus_if.up_TLAST  = 1'b0;
        wait_ready("mid_ready_timeout");
        @(posedge clk);
        #1;
        do_reset();
        send_packet(2);
        send_packet(1);

        do_reset();
        run_soak();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
